dec_ctrl_swc: RTL and testbench
===============================

DEC_CTRL_SWC -- requirements
Module: dec_ctrl_swc

Interface
REQ-001 Parameter LAST_CYCLE, default 4'd3, is the final cycle_cnt value of an instruction (legal range 1..15).
REQ-002 Parameter PC_OFFSET, default 32'd8, is the offset added to the fetch address before it is driven on pc.
REQ-003 hclk  input  1  clock; all state updates on its rising edge.
REQ-004 hrstn  input  1  asynchronous, active-low reset.
REQ-005 ifu_instr_valid  input  1  fetch unit presents an instruction.
REQ-006 ifu_instr  input  32  instruction word.
REQ-007 ifu_pc  input  32  address of ifu_instr.
REQ-008 exu_stall  input  1  execution stage requests a hold.
REQ-009 instr_ready  output  1  block can accept an instruction this cycle.
REQ-010 cycle_cnt  output  4  per-instruction cycle counter consumed by the execution units.
REQ-011 pc  output  32  latched ifu_pc + PC_OFFSET.
REQ-012 dec_upper_en, dec_lui, dec_auipc  output  1 each  U-type decode flags.
REQ-013 dec_imm_type_u  output  20  instr[31:12].
REQ-014 dec_rd  output  5  instr[11:7].
REQ-015 dec_illegal  output  1  instr[1:0] != 2'b11.
REQ-016 instr_retire  output  1  single-cycle pulse marking the final cycle of an instruction.

Function
REQ-017 The FSM SHALL have two states: IDLE and RUN.
REQ-018 instr_ready SHALL be 1 only in IDLE with exu_stall=0.
REQ-019 An instruction SHALL be accepted when ifu_instr_valid and instr_ready are both 1 at a rising edge. ifu_instr and ifu_pc SHALL be ignored at all other times.
REQ-020 On accept, the next state SHALL be RUN with cycle_cnt=0, and all dec_* outputs and pc SHALL be loaded from the accepted instruction in the same edge.
REQ-021 Decode rules:
 - dec_lui=1 iff instr[6:0]=7'b0110111.
 - dec_auipc=1 iff instr[6:0]=7'b0010111.
 - dec_upper_en = dec_lui | dec_auipc.
REQ-022 dec_imm_type_u, dec_rd and dec_illegal SHALL load for every opcode. An illegal or non-U-type instruction SHALL still run the full cycle sequence, with dec_upper_en=0.
REQ-023 In RUN, cycle_cnt SHALL increment by 1 per edge while exu_stall=0 and hold while exu_stall=1.
REQ-024 instr_retire SHALL equal (state==RUN && cycle_cnt==LAST_CYCLE && !exu_stall), combinationally.
REQ-025 On the edge where instr_retire=1, the next state SHALL be IDLE, and the following SHALL clear to 0: cycle_cnt, all dec_* outputs and pc.
REQ-026 dec_* outputs and pc SHALL be held constant for the whole of RUN, including stalled cycles.
REQ-027 In IDLE, cycle_cnt=0 and all dec_* outputs SHALL be 0.
REQ-028 cycle_cnt SHALL never exceed LAST_CYCLE. No wrap-around is permitted.
REQ-029 pc arithmetic is 32-bit modulo. ifu_pc=32'hFFFFFFFC SHALL give pc=32'h00000004.
REQ-030 Back-to-back instructions are not overlapped. The minimum spacing between accepts is LAST_CYCLE+2 cycles.
REQ-031 If exu_stall=1 in IDLE, no instruction SHALL be accepted even with ifu_instr_valid=1.

Reset
REQ-032 While hrstn=0, every output SHALL be 0 except instr_ready, and state SHALL be IDLE, independent of hclk.
REQ-033 instr_ready SHALL read 0 during reset and 1 from the first edge after hrstn deasserts, provided exu_stall=0.
REQ-034 Reset asserted during RUN SHALL abort the instruction immediately with no instr_retire pulse.

Verification
REQ-035 LUI x5,0x12345: ifu_instr=32'h123452B7, ifu_pc=32'h0 -> during RUN dec_lui=1, dec_upper_en=1, dec_rd=5, dec_imm_type_u=20'h12345, pc=32'h8. cycle_cnt steps 0,1,2,3, instr_retire pulses at cnt=3, then IDLE.
REQ-036 AUIPC x1,1: ifu_instr=32'h00001097, ifu_pc=32'h100 -> dec_auipc=1, dec_rd=1, dec_imm_type_u=20'h00001, pc=32'h108. The downstream unit computes 32'h1100.
REQ-037 Stall: exu_stall=1 for 2 cycles while cycle_cnt=1 -> cycle_cnt holds at 1 for 3 cycles, dec_* outputs are stable, and retire is delayed by 2 cycles.
REQ-038 Illegal: ifu_instr=32'h00000000 -> dec_illegal=1, dec_upper_en=0, full 4-cycle sequence, instr_retire pulses.
REQ-039 Reset mid-op: hrstn=0 at cycle_cnt=2 -> all outputs clear asynchronously with no retire. The next valid instruction is accepted normally after reset release.
REQ-040 Held valid: ifu_instr_valid=1 continuously -> accepts are exactly LAST_CYCLE+2 cycles apart, with no accept during RUN or while exu_stall=1 in IDLE.

Source files
------------

// File: rtl/dec_ctrl_swc.sv
// Decode/control sequencer: accepts one instruction, decodes U-type fields,
// then steps a per-instruction cycle counter until the final cycle retires it.
module dec_ctrl_swc #(
  parameter logic [3:0]  LAST_CYCLE = 4'd3,
  parameter logic [31:0] PC_OFFSET  = 32'd8
) (
  input  logic        hclk,
  input  logic        hrstn,
  input  logic        ifu_instr_valid,
  input  logic [31:0] ifu_instr,
  input  logic [31:0] ifu_pc,
  input  logic        exu_stall,
  output logic        instr_ready,
  output logic [3:0]  cycle_cnt,
  output logic [31:0] pc,
  output logic        dec_upper_en,
  output logic        dec_lui,
  output logic        dec_auipc,
  output logic [19:0] dec_imm_type_u,
  output logic [4:0]  dec_rd,
  output logic        dec_illegal,
  output logic        instr_retire
);

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   out_of_reset;
  logic   accept;
  logic   lui_c;
  logic   auipc_c;

  // Ready stays low until the first edge after reset release.
  assign instr_ready  = out_of_reset & (state == IDLE) & ~exu_stall;
  assign accept       = ifu_instr_valid & instr_ready;
  assign instr_retire = (state == RUN) & (cycle_cnt == LAST_CYCLE) & ~exu_stall;
  assign lui_c        = (ifu_instr[6:0] == OPC_LUI);
  assign auipc_c      = (ifu_instr[6:0] == OPC_AUIPC);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)       state_nxt = RUN;
      RUN:     if (instr_retire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state        <= IDLE;
      out_of_reset <= 1'b0;
    end else begin
      state        <= state_nxt;
      out_of_reset <= 1'b1;
    end
  end

  // Decode fields are captured once on accept and held until retire clears them.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      cycle_cnt      <= 4'd0;
      pc             <= 32'd0;
      dec_upper_en   <= 1'b0;
      dec_lui        <= 1'b0;
      dec_auipc      <= 1'b0;
      dec_imm_type_u <= 20'd0;
      dec_rd         <= 5'd0;
      dec_illegal    <= 1'b0;
    end else if (accept) begin
      cycle_cnt      <= 4'd0;
      pc             <= ifu_pc + PC_OFFSET;
      dec_upper_en   <= lui_c | auipc_c;
      dec_lui        <= lui_c;
      dec_auipc      <= auipc_c;
      dec_imm_type_u <= ifu_instr[31:12];
      dec_rd         <= ifu_instr[11:7];
      dec_illegal    <= (ifu_instr[1:0] != 2'b11);
    end else if (instr_retire) begin
      cycle_cnt      <= 4'd0;
      pc             <= 32'd0;
      dec_upper_en   <= 1'b0;
      dec_lui        <= 1'b0;
      dec_auipc      <= 1'b0;
      dec_imm_type_u <= 20'd0;
      dec_rd         <= 5'd0;
      dec_illegal    <= 1'b0;
    end else if ((state == RUN) && !exu_stall) begin
      cycle_cnt      <= cycle_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_dec_ctrl_swc.sv
// Directed bench for dec_ctrl_swc: stimulus pushes expected decode records,
// a negedge monitor pops them on accept and tracks the run to retire.
module tb_dec_ctrl_swc;

  localparam logic [3:0] LAST = 4'd3;

  typedef struct {
    logic [63:0] outs;
    int          run_len;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hrstn;
  logic        ifu_instr_valid;
  logic [31:0] ifu_instr;
  logic [31:0] ifu_pc;
  logic        exu_stall;
  logic        instr_ready;
  logic [3:0]  cycle_cnt;
  logic [31:0] pc;
  logic        dec_upper_en;
  logic        dec_lui;
  logic        dec_auipc;
  logic [19:0] dec_imm_type_u;
  logic [4:0]  dec_rd;
  logic        dec_illegal;
  logic        instr_retire;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  // Monitor model state
  logic live = 1'b0;
  logic inflight = 1'b0;
  logic exp_ready;
  logic exp_ret;
  logic [3:0] exp_cnt;
  int   run_cnt;
  int   acc_cnt = 0;
  int   cyc = 0;
  int   last_acc = 0;
  logic chk_spacing = 1'b0;
  logic prev_sp = 1'b0;
  exp_t cur;

  dec_ctrl_swc #(.LAST_CYCLE(4'd3), .PC_OFFSET(32'd8)) dut (
    .hclk(hclk), .hrstn(hrstn), .ifu_instr_valid(ifu_instr_valid),
    .ifu_instr(ifu_instr), .ifu_pc(ifu_pc), .exu_stall(exu_stall),
    .instr_ready(instr_ready), .cycle_cnt(cycle_cnt), .pc(pc),
    .dec_upper_en(dec_upper_en), .dec_lui(dec_lui), .dec_auipc(dec_auipc),
    .dec_imm_type_u(dec_imm_type_u), .dec_rd(dec_rd),
    .dec_illegal(dec_illegal), .instr_retire(instr_retire)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dut_outs();
    return {3'b0, dec_upper_en, dec_lui, dec_auipc, dec_illegal,
            dec_rd, dec_imm_type_u, pc};
  endfunction

  function automatic exp_t mk(input logic up, input logic lui, input logic auipc,
                              input logic ill, input logic [4:0] rd,
                              input logic [19:0] imm, input logic [31:0] p,
                              input int run_len);
    exp_t e;
    e.outs    = {3'b0, up, lui, auipc, ill, rd, imm, p};
    e.run_len = run_len;
    return e;
  endfunction

  // Readiness model: goes live on the first edge after reset release.
  always @(posedge hclk or negedge hrstn) begin
    if (!hrstn) live <= 1'b0;
    else        live <= 1'b1;
  end

  always @(negedge hclk) begin
    cyc++;
    if (!hrstn) begin
      inflight = 1'b0;
      chk("rst_outs", dut_outs(), 64'd0);
      chk("rst_ctl", {59'd0, instr_ready, instr_retire, cycle_cnt}, 64'd0);
    end else begin
      exp_ready = live && !inflight && !exu_stall;
      chk("instr_ready", {63'd0, instr_ready}, {63'd0, exp_ready});
      if (inflight) begin
        run_cnt++;
        exp_ret = (exp_cnt == LAST) && !exu_stall;
        chk("cycle_cnt", {60'd0, cycle_cnt}, {60'd0, exp_cnt});
        chk("run_outs", dut_outs(), cur.outs);
        chk("retire", {63'd0, instr_retire}, {63'd0, exp_ret});
        if (exp_ret) begin
          chk("run_len", 64'(run_cnt), 64'(cur.run_len));
          inflight = 1'b0;
        end else if (!exu_stall) begin
          exp_cnt = exp_cnt + 4'd1;
        end
      end else begin
        chk("idle_outs", dut_outs(), 64'd0);
        chk("idle_ctl", {59'd0, instr_retire, cycle_cnt}, 64'd0);
        if (exp_ready && ifu_instr_valid) begin
          if (chk_spacing && prev_sp)
            chk("accept_spacing", 64'(cyc - last_acc), 64'(LAST + 4'd2));
          prev_sp  = chk_spacing;
          last_acc = cyc;
          acc_cnt++;
          if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_accept: got accept expected none at %0t", $time);
          end else begin
            cur      = sb_q.pop_front();
            inflight = 1'b1;
            exp_cnt  = 4'd0;
            run_cnt  = 0;
          end
        end
      end
    end
  end

  task automatic wait_acc(input int target);
    for (int i = 0; i < 60; i++) begin
      if (acc_cnt >= target) break;
      @(negedge hclk); #1;
    end
    chk("accept_seen", 64'(acc_cnt >= target), 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!inflight) break;
      @(negedge hclk); #1;
    end
    chk("retire_seen", {63'd0, inflight}, 64'd0);
    @(posedge hclk); #1;
  endtask

  // Drive one instruction and return just after the accepting edge.
  task automatic issue(input logic [31:0] instr, input logic [31:0] ipc, input exp_t e);
    int base;
    sb_q.push_back(e);
    base            = acc_cnt;
    ifu_instr       = instr;
    ifu_pc          = ipc;
    ifu_instr_valid = 1'b1;
    wait_acc(base + 1);
    @(posedge hclk); #1;
    ifu_instr_valid = 1'b0;
    ifu_instr       = 32'hDEADBEEF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    hrstn = 1'b0; ifu_instr_valid = 1'b0; ifu_instr = 32'd0;
    ifu_pc = 32'd0; exu_stall = 1'b0;
    #3;
    chk("por_outs", dut_outs(), 64'd0);
    chk("por_ready", {63'd0, instr_ready}, 64'd0);
    repeat (2) @(posedge hclk);
    #1 hrstn = 1'b1;
    #1 chk("ready_before_edge", {63'd0, instr_ready}, 64'd0);
    @(posedge hclk); #1;
    chk("ready_after_edge", {63'd0, instr_ready}, 64'd1);

    // LUI x5,0x12345
    issue(32'h123452B7, 32'h0, mk(1, 1, 0, 0, 5'd5, 20'h12345, 32'h8, 4));
    wait_idle();
    // AUIPC x1,1
    issue(32'h00001097, 32'h100, mk(1, 0, 1, 0, 5'd1, 20'h00001, 32'h108, 4));
    wait_idle();
    // LUI x0 with pc wrap, stalled two cycles at cnt=1
    issue(32'hFFFFF037, 32'hFFFFFFFC, mk(1, 1, 0, 0, 5'd0, 20'hFFFFF, 32'h4, 6));
    @(posedge hclk); #1;
    exu_stall = 1'b1;
    repeat (2) @(posedge hclk);
    #1 exu_stall = 1'b0;
    wait_idle();
    // Illegal all-zero word
    issue(32'h00000000, 32'h20, mk(0, 0, 0, 1, 5'd0, 20'h0, 32'h28, 4));
    wait_idle();
    // ADDI x3,x0,10: legal, not U-type
    issue(32'h00A00193, 32'h40, mk(0, 0, 0, 0, 5'd3, 20'h00A00, 32'h48, 4));
    wait_idle();

    // Reset at cycle_cnt=2 aborts without retire
    issue(32'h123452B7, 32'h0, mk(1, 1, 0, 0, 5'd5, 20'h12345, 32'h8, 4));
    repeat (2) @(posedge hclk);
    #2 hrstn = 1'b0;
    #1;
    chk("async_rst_outs", dut_outs(), 64'd0);
    chk("async_rst_ctl", {59'd0, instr_ready, instr_retire, cycle_cnt}, 64'd0);
    repeat (2) @(posedge hclk);
    #1 hrstn = 1'b1;
    #1 chk("ready_after_rst", {63'd0, instr_ready}, 64'd0);
    issue(32'h00001097, 32'h200, mk(1, 0, 1, 0, 5'd1, 20'h00001, 32'h208, 4));
    wait_idle();

    // Valid held high: back-to-back accepts, then stall in IDLE blocks accept
    chk_spacing = 1'b1;
    for (int i = 0; i < 3; i++)
      sb_q.push_back(mk(1, 0, 1, 0, 5'd1, 20'h00001, 32'h308, 4));
    base            = acc_cnt;
    ifu_instr       = 32'h00001097;
    ifu_pc          = 32'h300;
    ifu_instr_valid = 1'b1;
    wait_acc(base + 3);
    @(posedge hclk); #1;
    repeat (4) @(posedge hclk);
    #1 exu_stall = 1'b1;
    chk_spacing = 1'b0;
    ifu_pc = 32'h400;
    sb_q.push_back(mk(1, 0, 1, 0, 5'd1, 20'h00001, 32'h408, 4));
    repeat (3) @(posedge hclk);
    #1 chk("no_accept_stalled", 64'(acc_cnt), 64'(base + 3));
    exu_stall = 1'b0;
    wait_acc(base + 4);
    @(posedge hclk); #1;
    ifu_instr_valid = 1'b0;
    wait_idle();

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
